rm_ihpsg13_1p_march_bist_ctrl: RTL and testbench

// - March C- BIST engine that drives the A_BIST_* port of a 1P SRAM macro with byte/bit-mask and BIST mux.
// - On START it takes the BIST port (A_BIST_EN=1) and walks every address with the six March C- elements.
// - It compares A_DOUT against the expected background and reports BUSY, DONE and FAIL.
// - One instance per macro; sits beside the macro and is clocked by the same net as A_BIST_CLK.

---
 rtl/rm_ihpsg13_1p_march_bist_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rm_ihpsg13_1p_march_bist_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/rm_ihpsg13_1p_march_bist_ctrl.sv
// rm_ihpsg13_1p_march_bist_ctrl: March C- BIST engine for a 1P SRAM macro BIST port.
// Optional RM_BIST_FAIL_CAPTURE_EN builds first-mismatch address/element/bits capture.
module rm_ihpsg13_1p_march_bist_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int BG_ALT = 0
) (
   input  logic              A_BIST_CLK,
   input  logic              A_BIST_RST_N,
   input  logic              START,
   output logic              A_BIST_EN,
   output logic              A_BIST_MEN,
   output logic              A_BIST_WEN,
   output logic              A_BIST_REN,
   output logic [ADDR_W-1:0] A_BIST_ADDR,
   output logic [DATA_W-1:0] A_BIST_DIN,
   output logic [DATA_W-1:0] A_BIST_BM,
   input  logic [DATA_W-1:0] A_DOUT,
   output logic              BIST_BUSY,
   output logic              BIST_DONE,
   output logic              BIST_FAIL,
   output logic [ADDR_W-1:0] BIST_FAIL_ADDR,
   output logic [2:0]        BIST_FAIL_ELEM,
   output logic [DATA_W-1:0] BIST_FAIL_BITS
);
   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] D0 = (BG_ALT != 0) ? {(DATA_W/2){2'b01}} : '0;
   localparam logic [DATA_W-1:0] D1 = ~D0;

   logic [1:0]        r_state, w_state;
   logic [2:0]        r_elem, w_elem;
   logic              r_ph, w_ph;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic              r_men, r_wen, r_ren, r_busy, r_done, r_fail, r_cmp_vld;
   logic [DATA_W-1:0] r_din, r_exp;
   logic              w_two, w_down, w_term, w_step, w_start, w_mis;
   logic              w_run, w_wr, w_busy;
   logic [DATA_W-1:0] w_din, w_exp;

   // ph selects the read (0) or write (1) half of a two-op element
   assign w_two   = (r_elem != 3'd0) && (r_elem != 3'd5);
   assign w_down  = r_elem >= 3'd3;
   assign w_term  = w_down ? (r_addr == '0) : (r_addr == LAST);
   assign w_step  = !w_two || r_ph;
   assign w_start = START && (r_state == S_IDLE || r_state == S_DONE);
   assign w_mis   = r_cmp_vld && (A_DOUT != r_exp);

   always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
      if (!A_BIST_RST_N) begin
         r_state   <= S_IDLE;
         r_elem    <= '0;
         r_ph      <= 1'b0;
         r_addr    <= '0;
         r_men     <= 1'b0;
         r_wen     <= 1'b0;
         r_ren     <= 1'b0;
         r_din     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_fail    <= 1'b0;
         r_cmp_vld <= 1'b0;
         r_exp     <= '0;
      end else begin
         r_state   <= w_state;
         r_elem    <= w_elem;
         r_ph      <= w_ph;
         r_addr    <= w_addr;
         r_men     <= w_run;
         r_wen     <= w_run && w_wr;
         r_ren     <= w_run && !w_wr;
         r_din     <= w_din;
         r_busy    <= w_busy;
         r_done    <= w_state == S_DONE;
         r_fail    <= w_start ? 1'b0 : (r_fail || w_mis);
         r_cmp_vld <= r_ren;
         r_exp     <= w_exp;
      end
   end

   always_comb begin
      w_state = r_state;
      w_elem  = r_elem;
      w_ph    = r_ph;
      w_addr  = r_addr;
      case (r_state)
         S_IDLE, S_DONE: if (START) begin
            w_state = S_RUN;
            w_elem  = '0;
            w_ph    = 1'b0;
            w_addr  = '0;
         end
         S_RUN: if (!w_step) begin
            w_ph = 1'b1;
         end else if (!w_term) begin
            w_ph   = 1'b0;
            w_addr = w_down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
         end else if (r_elem == 3'd5) begin
            w_state = S_DRAIN;
         end else begin
            w_elem = r_elem + 3'd1;
            w_ph   = 1'b0;
            w_addr = (r_elem >= 3'd2) ? LAST : '0;
         end
         default: w_state = S_DONE;
      endcase
   end

   // next-cycle macro controls, registered above
   always_comb begin
      w_run  = w_state == S_RUN;
      w_busy = w_run || (w_state == S_DRAIN);
      w_wr   = (w_elem == 3'd0) || ((w_elem != 3'd5) && w_ph);
      w_din  = w_run ? (((w_elem == 3'd1) || (w_elem == 3'd3)) ? D1 : D0) : '0;
      w_exp  = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? D1 : D0;
   end

   assign A_BIST_EN   = r_busy;
   assign A_BIST_MEN  = r_men;
   assign A_BIST_WEN  = r_wen;
   assign A_BIST_REN  = r_ren;
   assign A_BIST_ADDR = r_addr;
   assign A_BIST_DIN  = r_din;
   assign A_BIST_BM   = {DATA_W{r_busy}};
   assign BIST_BUSY   = r_busy;
   assign BIST_DONE   = r_done;
   assign BIST_FAIL   = r_fail;

`ifdef RM_BIST_FAIL_CAPTURE_EN
   logic [ADDR_W-1:0] r_cmp_addr, r_fail_addr;
   logic [2:0]        r_cmp_elem, r_fail_elem;
   logic [DATA_W-1:0] r_fail_bits;

   always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
      if (!A_BIST_RST_N) begin
         r_cmp_addr  <= '0;
         r_cmp_elem  <= '0;
         r_fail_addr <= '0;
         r_fail_elem <= '0;
         r_fail_bits <= '0;
      end else begin
         r_cmp_addr <= r_addr;
         r_cmp_elem <= r_elem;
         if (w_start) begin
            r_fail_addr <= '0;
            r_fail_elem <= '0;
            r_fail_bits <= '0;
         end else if (w_mis && !r_fail) begin
            r_fail_addr <= r_cmp_addr;
            r_fail_elem <= r_cmp_elem;
            r_fail_bits <= A_DOUT ^ r_exp;
         end
      end
   end

   assign BIST_FAIL_ADDR = r_fail_addr;
   assign BIST_FAIL_ELEM = r_fail_elem;
   assign BIST_FAIL_BITS = r_fail_bits;
`else
   assign BIST_FAIL_ADDR = '0;
   assign BIST_FAIL_ELEM = '0;
   assign BIST_FAIL_BITS = '0;
`endif
endmodule

// File: tb/tb_rm_ihpsg13_1p_march_bist_ctrl.sv
// tb_rm_ihpsg13_1p_march_bist_ctrl: March C- BIST bench with a behavioural 512x64 macro,
// an op-stream scoreboard and a table of landmark ops.
module tb_rm_ihpsg13_1p_march_bist_ctrl;
   localparam int N = 512;
   localparam int NOPS = 10 * N;
`ifdef RM_BIST_FAIL_CAPTURE_EN
   localparam bit CAP = 1'b1;
`else
   localparam bit CAP = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic        en, men, wen, ren, busy, done, fail;
   logic [8:0]  addr, fail_addr;
   logic [63:0] din, bm, dout, fail_bits;
   logic [2:0]  fail_elem;

   always #5 clk = ~clk;

   rm_ihpsg13_1p_march_bist_ctrl dut (
      .A_BIST_CLK(clk), .A_BIST_RST_N(rst_n), .START(start),
      .A_BIST_EN(en), .A_BIST_MEN(men), .A_BIST_WEN(wen), .A_BIST_REN(ren),
      .A_BIST_ADDR(addr), .A_BIST_DIN(din), .A_BIST_BM(bm), .A_DOUT(dout),
      .BIST_BUSY(busy), .BIST_DONE(done), .BIST_FAIL(fail),
      .BIST_FAIL_ADDR(fail_addr), .BIST_FAIL_ELEM(fail_elem), .BIST_FAIL_BITS(fail_bits)
   );

   // behavioural macro: read latency 1, optional stuck-at-1 on bit 5 of word 0x1A5
   logic [63:0] mem [N];
   bit          fault_en = 1'b0;
   initial dout = '0;
   always @(posedge clk) if (men) begin
      if (wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
      if (ren) dout <= mem[addr] | ((fault_en && addr == 9'h1A5) ? 64'h20 : 64'h0);
   end

   typedef struct { bit we; bit re; int addr; logic [63:0] din; } op_t;
   typedef struct { int op; bit we; int addr; logic [63:0] din; } vec_t;
   op_t         exp_q[$];
   logic        rec_we   [NOPS+1];
   int          rec_addr [NOPS+1];
   logic [63:0] rec_din  [NOPS+1];
   logic [63:0] rec_bm   [NOPS+1];
   vec_t        vecs [6];
   int          checks = 0, failures = 0;
   int          de;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_march();
      exp_q.delete();
      for (int m = 0; m < 6; m++)
         for (int i = 0; i < N; i++) begin
            int a;
            a = (m < 3) ? i : N - 1 - i;
            if (m != 0) exp_q.push_back('{1'b0, 1'b1, a, 64'h0});
            if (m != 5) exp_q.push_back('{1'b1, 1'b0, a, (m == 1 || m == 3) ? {64{1'b1}} : 64'h0});
         end
   endtask

   task automatic run(input int poke, output int done_edge);
      int  nops, serr, first_bad;
      op_t x;
      push_march();
      nops = 0; serr = 0; first_bad = -1; done_edge = -1;
      @(negedge clk) start = 1'b1;
      for (int e = 0; e < 6000; e++) begin
         @(posedge clk);
         @(negedge clk);
         start = (e + 1 == poke);
         if (e == 0) begin
            chk("start_busy", busy, 1'b1);
            chk("start_done_clear", done, 1'b0);
            chk("start_fail_clear", fail, 1'b0);
            chk("start_fail_addr_clear", fail_addr, 9'h0);
            chk("start_fail_bits_clear", fail_bits, 64'h0);
         end
         if (men) begin
            nops++;
            if (nops <= NOPS) begin
               rec_we[nops] = wen; rec_addr[nops] = addr; rec_din[nops] = din; rec_bm[nops] = bm;
            end
            if (exp_q.size() == 0) serr++;
            else begin
               x = exp_q.pop_front();
               if (wen !== x.we || ren !== x.re || addr !== x.addr[8:0] || (x.we && din !== x.din)) begin
                  serr++;
                  if (first_bad < 0) first_bad = nops;
               end
            end
         end
         if (en !== busy || bm !== (busy ? {64{1'b1}} : 64'h0)) serr++;
         if (done) begin done_edge = e; break; end
         if (!busy) serr++;
      end
      chk("seq_errors", serr, 0);
      chk("op_count", nops, NOPS);
      chk("queue_empty", exp_q.size(), 0);
      chk("done_edge", done_edge, 5121);
      if (first_bad >= 0) $display("first bad op %0d", first_bad);
      @(negedge clk);
      chk("post_busy", busy, 1'b0);
      chk("post_en", en, 1'b0);
      chk("post_men", men, 1'b0);
      chk("post_done_sticky", done, 1'b1);
   endtask

   initial begin
      vecs[0] = '{1,    1'b1, 0,   64'h0};
      vecs[1] = '{513,  1'b0, 0,   64'h0};
      vecs[2] = '{1536, 1'b1, 511, {64{1'b1}}};
      vecs[3] = '{2561, 1'b0, 511, 64'h0};
      vecs[4] = '{3584, 1'b1, 0,   {64{1'b1}}};
      vecs[5] = '{5120, 1'b0, 0,   64'h0};
      for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};

      #12;
      chk("rst_en", en, 1'b0);
      chk("rst_men", men, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_fail", fail, 1'b0);
      chk("rst_bm", bm, 64'h0);
      @(negedge clk) rst_n = 1'b1;

      run(-1, de);
      chk("clean_fail", fail, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("op%0d_we", vecs[i].op), rec_we[vecs[i].op], vecs[i].we);
         chk($sformatf("op%0d_addr", vecs[i].op), rec_addr[vecs[i].op], vecs[i].addr);
         if (vecs[i].we) chk($sformatf("op%0d_din", vecs[i].op), rec_din[vecs[i].op], vecs[i].din);
         chk($sformatf("op%0d_bm", vecs[i].op), rec_bm[vecs[i].op], {64{1'b1}});
      end

      fault_en = 1'b1;
      run(-1, de);
      chk("fault_fail", fail, 1'b1);
      chk("fault_addr", fail_addr, CAP ? 9'h1A5 : 9'h0);
      chk("fault_elem", fail_elem, CAP ? 3'd1 : 3'd0);
      chk("fault_bits", fail_bits, CAP ? 64'h20 : 64'h0);
      fault_en = 1'b0;

      run(-1, de);
      chk("restart_fail", fail, 1'b0);
      chk("restart_fail_elem", fail_elem, 3'd0);

      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (299) @(posedge clk);
      #2;
      chk("pre_rst_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_en", en, 1'b0);
      chk("async_rst_men", men, 1'b0);
      chk("async_rst_wen", wen, 1'b0);
      chk("async_rst_addr", addr, 9'h0);
      chk("async_rst_din", din, 64'h0);
      chk("async_rst_bm", bm, 64'h0);
      chk("async_rst_done", done, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      run(-1, de);
      chk("after_rst_fail", fail, 1'b0);

      run(1000, de);
      chk("poke_fail", fail, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
